// File: rtl/complementary_dead_time_generator_pkg.sv
// Shared definitions for the complementary dead-time generator.
//   dt_state_e : per-channel FSM state (3-bit encoding, OFF = 0 so reset is all-zero)
//   CntLoad    : value loaded into the dead-time counter on entry to a DT state
package complementary_dead_time_generator_pkg;

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_DT_TO_HI = 3'd1,
      ST_HI_ON    = 3'd2,
      ST_DT_TO_LO = 3'd3,
      ST_LO_ON    = 3'd4
   } dt_state_e;

   localparam int unsigned CntLoad = 1;

endpackage

// File: rtl/dead_time_channel.sv
// One complementary switch pair: FSM, dead-time counter, shadowed dead-time word
// and registered gate outputs.
//   clk_i, rst_ni      : clock, async active-low reset
//   force_off          : disable or kill; wins over every other transition
//   run                : channel may leave OFF
//   pwm                : registered gate command (1 = high side on)
//   dt_rise, dt_fall   : dead-time words sampled on entry to DT_TO_HI / DT_TO_LO
//   hi, lo, dt_active  : registered outputs decoded from the next state
module dead_time_channel
   import complementary_dead_time_generator_pkg::*;
#(
   parameter int unsigned DeadTimeWidth = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     force_off,
   input  logic                     run,
   input  logic                     pwm,
   input  logic [DeadTimeWidth-1:0] dt_rise,
   input  logic [DeadTimeWidth-1:0] dt_fall,
   output logic                     hi,
   output logic                     lo,
   output logic                     dt_active
);

   dt_state_e                state_q, state_d;
   logic [DeadTimeWidth-1:0] cnt_q, cnt_d;
   logic [DeadTimeWidth-1:0] shadow_q, shadow_d;

   // Next-state, counter and shadow logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      if (force_off) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (run) begin
                  cnt_d = DeadTimeWidth'(CntLoad);
                  if (pwm) begin
                     state_d  = ST_DT_TO_HI;
                     shadow_d = dt_rise;
                  end else begin
                     state_d  = ST_DT_TO_LO;
                     shadow_d = dt_fall;
                  end
               end
            end
            ST_DT_TO_HI: begin
               // Reversal is an abort: the low side never stopped being safe
               if (!pwm)                    state_d = ST_LO_ON;
               else if (cnt_q >= shadow_q)  state_d = ST_HI_ON;
               else                         cnt_d   = cnt_q + DeadTimeWidth'(1);
            end
            ST_DT_TO_LO: begin
               if (pwm)                     state_d = ST_HI_ON;
               else if (cnt_q >= shadow_q)  state_d = ST_LO_ON;
               else                         cnt_d   = cnt_q + DeadTimeWidth'(1);
            end
            ST_HI_ON: begin
               if (!pwm) begin
                  state_d  = ST_DT_TO_LO;
                  cnt_d    = DeadTimeWidth'(CntLoad);
                  shadow_d = dt_fall;
               end
            end
            ST_LO_ON: begin
               if (pwm) begin
                  state_d  = ST_DT_TO_HI;
                  cnt_d    = DeadTimeWidth'(CntLoad);
                  shadow_d = dt_rise;
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
   end

   // State register with outputs decoded from the next state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_OFF;
         cnt_q     <= '0;
         shadow_q  <= '0;
         hi        <= 1'b0;
         lo        <= 1'b0;
         dt_active <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         hi        <= (state_d == ST_HI_ON);
         lo        <= (state_d == ST_LO_ON);
         dt_active <= (state_d == ST_DT_TO_HI) || (state_d == ST_DT_TO_LO);
      end
   end

endmodule

// File: rtl/complementary_dead_time_generator.sv
// Multi-channel complementary gate driver with programmable dead time and a
// sticky fault kill.
//   clk_i, rst_ni          : clock, async active-low reset
//   enable_i               : modulator enable (0 forces all channels OFF)
//   kill_i                 : fault kill; sets fault_o and forces all channels OFF
//   pwm_i                  : per-channel gate command
//   dt_rise_i, dt_fall_i   : both-low cycles before high-side / low-side turn-on
//   hi_o, lo_o             : gate drives
//   dt_active_o            : channel is in a dead interval
//   fault_o                : sticky kill flag, cleared by disabling without kill
module complementary_dead_time_generator
   import complementary_dead_time_generator_pkg::*;
#(
   parameter int unsigned NumChannels   = 2,
   parameter int unsigned DeadTimeWidth = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     enable_i,
   input  logic                     kill_i,
   input  logic [NumChannels-1:0]   pwm_i,
   input  logic [DeadTimeWidth-1:0] dt_rise_i,
   input  logic [DeadTimeWidth-1:0] dt_fall_i,
   output logic [NumChannels-1:0]   hi_o,
   output logic [NumChannels-1:0]   lo_o,
   output logic [NumChannels-1:0]   dt_active_o,
   output logic                     fault_o
);

   logic [NumChannels-1:0] pwm_q;
   logic                   pwm_vld_q;
   logic                   fault_q;
   logic                   force_off;
   logic                   run;

   // pwm_vld_q holds channels in OFF until pwm_q carries a real sample
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pwm_q     <= '0;
         pwm_vld_q <= 1'b0;
      end else begin
         pwm_q     <= pwm_i;
         pwm_vld_q <= 1'b1;
      end
   end

   // Sticky fault: only a disabled, kill-free edge clears it
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        fault_q <= 1'b0;
      else if (kill_i)    fault_q <= 1'b1;
      else if (!enable_i) fault_q <= 1'b0;
   end

   assign fault_o   = fault_q;
   assign force_off = !enable_i || kill_i;
   assign run       = enable_i && !fault_q && pwm_vld_q;

   for (genvar c = 0; c < NumChannels; c++) begin : g_ch
      dead_time_channel #(
         .DeadTimeWidth (DeadTimeWidth)
      ) u_ch (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .force_off (force_off),
         .run       (run),
         .pwm       (pwm_q[c]),
         .dt_rise   (dt_rise_i),
         .dt_fall   (dt_fall_i),
         .hi        (hi_o[c]),
         .lo        (lo_o[c]),
         .dt_active (dt_active_o[c])
      );
   end

endmodule

// File: doc/complementary_dead_time_generator.md
COMPLEMENTARY_DEAD_TIME_GENERATOR -- requirements
Module: complementary_dead_time_generator

Interface
REQ-001 The block SHALL have parameter NumChannels, default 2, giving the number of independent complementary switch pairs.
REQ-002 The block SHALL have parameter DeadTimeWidth, default 5, giving the width of the dead-time words and counters.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with the following ports:
- clk_i  in  1  sole clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  modulator enable.
- kill_i  in  1  fault kill request.
- pwm_i  in  NumChannels  per-channel gate command (1 = high-side switch on).
- dt_rise_i  in  DeadTimeWidth  both-low cycles before high-side turn-on.
- dt_fall_i  in  DeadTimeWidth  both-low cycles before low-side turn-on.
- hi_o  out  NumChannels  high-side gate drive.
- lo_o  out  NumChannels  low-side gate drive.
- dt_active_o  out  NumChannels  channel is in a dead interval.
- fault_o  out  1  sticky kill flag.

Function
REQ-004 pwm_i SHALL be registered once into pwm_q before any use; all channel logic SHALL act on pwm_q.
REQ-005 Each channel SHALL run an independent FSM with states OFF, DT_TO_HI, HI_ON, DT_TO_LO and LO_ON.
REQ-006 hi_o, lo_o and dt_active_o SHALL be registered and decoded from the next state, as follows:
- hi_o = HI_ON.
- lo_o = LO_ON.
- dt_active_o = DT_TO_HI or DT_TO_LO.
REQ-007 hi_o and lo_o of one channel SHALL never be 1 in the same cycle.
REQ-008 OFF SHALL transition on run (enable_i=1 and fault_q=0):
- to DT_TO_HI if pwm_q=1.
- to DT_TO_LO if pwm_q=0.
REQ-009 LO_ON with pwm_q=1 SHALL transition to DT_TO_HI, and HI_ON with pwm_q=0 SHALL transition to DT_TO_LO.
REQ-010 On entry to a DT state, the channel SHALL:
- load its counter with 1;
- capture dt_rise_i (for DT_TO_HI) or dt_fall_i (for DT_TO_LO) into a per-channel shadow register.
Later changes to dt_*_i SHALL NOT affect an interval already in progress.
REQ-011 In a DT state with an unchanged command, the channel SHALL advance as follows:
- counter >= shadow: exit to HI_ON or LO_ON.
- otherwise: increment the counter.
The both-low interval is therefore max(shadow,1) cycles, and dt=0 SHALL behave as dt=1.
REQ-012 The counter SHALL be DeadTimeWidth bits wide and SHALL never wrap, because exit occurs at equality with the shadow value (maximum 2^DeadTimeWidth-1).
REQ-013 A command reversal inside a DT state SHALL be handled as an abort:
- DT_TO_HI with pwm_q=0 SHALL go to LO_ON on the next edge.
- DT_TO_LO with pwm_q=1 SHALL go to HI_ON on the next edge.
This is safe because the opposite switch never conducted.
REQ-014 Latency SHALL be:
- 1 cycle from a pwm_i edge to the pwm_q update;
- 1 further cycle to the outputs entering the DT state;
- N cycles of dead time, where N = max(shadow,1);
- so the active output asserts 2+N cycles after the pwm_i edge.
REQ-015 enable_i=0 SHALL force every channel to OFF (both outputs low) at the next edge, from any state.
REQ-016 kill_i=1 SHALL set fault_q at the next edge and force every channel to OFF.
REQ-017 fault_q SHALL stay set while enable_i=1, and SHALL clear only on an edge where enable_i=0 and kill_i=0; fault_o = fault_q.
REQ-018 If kill_i or a disable coincides with any FSM transition, the transition to OFF SHALL win.
REQ-019 If kill_i is asserted in the same cycle as a re-enable, OFF SHALL win.
REQ-020 Leaving OFF SHALL always pass through a full DT state; an output SHALL never assert directly from OFF.

Reset
REQ-021 While rst_ni=0, all of the following SHALL hold asynchronously:
- FSM state = OFF;
- hi_o=0, lo_o=0, dt_active_o=0, fault_o=0;
- pwm_q=0, counters=0, shadows=0.
REQ-022 Reset release SHALL be followed by a first transition no earlier than the second clk_i edge, because pwm_q must first be sampled.

Structure
REQ-023 A shared package SHALL hold the FSM state enumeration (5 states, 3-bit encoding) and the counter-load constant 1.
REQ-024 One sub-module, dead_time_channel, SHALL hold the FSM, counter, shadow and output flops for a single pair.
REQ-025 The top level SHALL contain:
- the pwm_q register;
- the fault_q logic;
- a generate loop of NumChannels dead_time_channel instances.

Verification
REQ-026 The bench SHALL cover at least the following scenarios (DeadTimeWidth=5, NumChannels=2):
- Basic rise/fall: run, dt_rise=4, dt_fall=3, pwm_i[0] 0->1 at edge k -> lo_o[0] falls at k+2, hi_o[0] rises at k+6; pwm_i[0] 1->0 at edge m -> hi_o[0] falls at m+2, lo_o[0] rises at m+5.
- Zero dead time: dt_rise=0, pwm_i[1] rises at edge k -> exactly 1 both-low cycle, hi_o[1] rises at k+3.
- Abort: dt_rise=10, pwm_i[0] pulse of 3 cycles -> hi_o[0] never asserts, lo_o[0] returns, with no cycle where hi_o=lo_o=1.
- Kill: kill_i pulse during HI_ON -> all outputs 0 next edge and fault_o=1; re-enable attempt with enable_i held 1 -> outputs stay 0; enable_i=0 then 1 -> fault_o clears and channels pass through a DT state.
- Async reset: rst_ni asserted mid dead interval -> outputs 0 immediately without a clock edge; after release, channels start from OFF.
- Shadow capture: dt_rise changed 7->2 mid interval -> interval still lasts 7 cycles.
